// File: rtl/ikaopm_pkg.sv
// rtl/ikaopm_pkg.sv - shared IKAOPM constants and types
package ikaopm_pkg;
    localparam int SLOT_NUM        = 32;
    localparam int CYCLE_W         = 5;
    localparam int IC_HOLD_DEFAULT = 64;

    typedef logic [CYCLE_W-1:0] cycle_t;
endpackage

// File: rtl/ikaopm_timinggen_cengen.sv
// rtl/ikaopm_timinggen_cengen.sv - phi1 state flop and active-low PCEN/NCEN decode
module ikaopm_timinggen_cengen (
    input  logic i_EMUCLK,
    input  logic i_RST_n,
    input  logic i_PHIMCEN_n,
    output logic o_PCEN_n,
    output logic o_NCEN_n
);
    logic r_phi1_q;

    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_phi1_q <= 1'b0;
        end else if (!i_PHIMCEN_n) begin
            r_phi1_q <= ~r_phi1_q;
        end
    end

    // Gated by reset combinationally so an async reset never leaves a partial pulse.
    assign o_PCEN_n = ~(i_RST_n & ~i_PHIMCEN_n & ~r_phi1_q);
    assign o_NCEN_n = ~(i_RST_n & ~i_PHIMCEN_n &  r_phi1_q);
endmodule

// File: rtl/ikaopm_timinggen.sv
// rtl/ikaopm_timinggen.sv - phi1 enables, slot counter and IC conditioning (IKAOPM_TIMINGGEN_IC_STRETCH_EN)
module ikaopm_timinggen
    import ikaopm_pkg::*;
#(
    parameter int IC_HOLD = IC_HOLD_DEFAULT
) (
    input  logic         i_EMUCLK,
    input  logic         i_RST_n,
    input  logic         i_PHIMCEN_n,
    input  logic         i_IC_n,
    output logic         o_PHI1PCEN_n,
    output logic         o_PHI1NCEN_n,
    output logic [4:0]   o_CYCLE,
    output logic         o_CYCLE_31,
    output logic         o_IC_n
);
    logic   w_pcen_n;
    logic   w_ncen_n;
    logic   w_ic_d;
    logic   r_ic_s1;
    logic   r_ic_s2;
    logic   r_ic_n;
    cycle_t r_cycle;

    if ((IC_HOLD < 1) || (IC_HOLD > 255)) begin : g_bad_ic_hold
        $error("IC_HOLD out of range");
    end

    ikaopm_timinggen_cengen u_cengen (
        .i_EMUCLK    (i_EMUCLK),
        .i_RST_n     (i_RST_n),
        .i_PHIMCEN_n (i_PHIMCEN_n),
        .o_PCEN_n    (w_pcen_n),
        .o_NCEN_n    (w_ncen_n)
    );

    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_ic_s1 <= 1'b0;
            r_ic_s2 <= 1'b0;
        end else if (!w_ncen_n) begin
            r_ic_s1 <= i_IC_n;
            r_ic_s2 <= r_ic_s1;
        end
    end

`ifdef IKAOPM_TIMINGGEN_IC_STRETCH_EN
    localparam logic [7:0] LP_HOLD = 8'(IC_HOLD);
    logic [7:0] r_hold_cnt;

    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_hold_cnt <= 8'd0;
        end else if (!r_ic_s2) begin
            r_hold_cnt <= 8'd0;
        end else if (!w_pcen_n && (r_hold_cnt != LP_HOLD)) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
        end
    end

    assign w_ic_d = r_ic_s2 && (r_hold_cnt == LP_HOLD);
`else
    assign w_ic_d = r_ic_s2;
`endif

    // Counter clears on the edge IC asserts and stays at 0 on the releasing edge,
    // so slot 0 is the period in which o_IC_n deasserted.
    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_ic_n  <= 1'b0;
            r_cycle <= '0;
        end else if (!w_pcen_n) begin
            r_ic_n <= w_ic_d;
            if (!w_ic_d || !r_ic_n) begin
                r_cycle <= '0;
            end else begin
                r_cycle <= r_cycle + cycle_t'(1);
            end
        end
    end

    assign o_PHI1PCEN_n = w_pcen_n;
    assign o_PHI1NCEN_n = w_ncen_n;
    assign o_CYCLE      = r_cycle;
    assign o_CYCLE_31   = (r_cycle == cycle_t'(SLOT_NUM - 1));
    assign o_IC_n       = r_ic_n;
endmodule

// File: tb/tb_ikaopm_timinggen.sv
// tb/tb_ikaopm_timinggen.sv - directed bench for ikaopm_timinggen (IKAOPM_TIMINGGEN_IC_STRETCH_EN aware)
module tb_ikaopm_timinggen;
    localparam int HOLD = 64;
`ifdef IKAOPM_TIMINGGEN_IC_STRETCH_EN
    localparam int REL_N  = HOLD + 1;
    localparam int MID_N  = 30;
`else
    localparam int REL_N  = 1;
    localparam int MID_N  = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       phimcen_n;
    logic       ic_n;
    logic       pcen_n;
    logic       ncen_n;
    logic [4:0] cycle;
    logic       cycle_31;
    logic       ic_out_n;

    int checks   = 0;
    int failures = 0;
    int seq_err  = 0;

    ikaopm_timinggen #(.IC_HOLD(HOLD)) dut (
        .i_EMUCLK     (clk),
        .i_RST_n      (rst_n),
        .i_PHIMCEN_n  (phimcen_n),
        .i_IC_n       (ic_n),
        .o_PHI1PCEN_n (pcen_n),
        .o_PHI1NCEN_n (ncen_n),
        .o_CYCLE      (cycle),
        .o_CYCLE_31   (cycle_31),
        .o_IC_n       (ic_out_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One phiM period: three idle clocks then one enabled clock.
    task automatic phim(output logic p, output logic n);
        p = 1'b1;
        n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            phimcen_n = (i == 3) ? 1'b0 : 1'b1;
            #1;
            if (i < 3) begin
                if (!pcen_n || !ncen_n) seq_err++;
            end else begin
                p = pcen_n;
                n = ncen_n;
            end
        end
        @(posedge clk);
        #1;
        phimcen_n = 1'b1;
    endtask

    task automatic period();
        logic p, n;
        phim(p, n);
        if (!(p === 1'b0 && n === 1'b1)) seq_err++;
        phim(p, n);
        if (!(p === 1'b1 && n === 1'b0)) seq_err++;
    endtask

    initial begin
        logic p, n;
        rst_n     = 1'b0;
        phimcen_n = 1'b0;
        ic_n      = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_pcen", {7'd0, pcen_n}, 8'd1);
        check("rst_ncen", {7'd0, ncen_n}, 8'd1);
        check("rst_cycle", {3'd0, cycle}, 8'd0);
        check("rst_cycle31", {7'd0, cycle_31}, 8'd0);
        check("rst_ic", {7'd0, ic_out_n}, 8'd0);
        rst_n     = 1'b1;
        phimcen_n = 1'b1;

        for (int k = 1; k <= 4; k++) begin
            phim(p, n);
            check($sformatf("en%0d_pcen", k), {7'd0, p}, (k % 2 == 1) ? 8'd0 : 8'd1);
            check($sformatf("en%0d_ncen", k), {7'd0, n}, (k % 2 == 0) ? 8'd0 : 8'd1);
        end
        check("ic_low_after_sync", {7'd0, ic_out_n}, 8'd0);

        for (int k = 1; k < REL_N; k++) period();
        check("ic_before_release", {7'd0, ic_out_n}, 8'd0);
        period();
        check("ic_release", {7'd0, ic_out_n}, 8'd1);
        check("slot0_at_release", {3'd0, cycle}, 8'd0);
        period();
        check("slot1", {3'd0, cycle}, 8'd1);
        for (int k = 0; k < 29; k++) period();
        check("slot30", {3'd0, cycle}, 8'd30);
        check("slot30_c31", {7'd0, cycle_31}, 8'd0);
        period();
        check("slot31", {3'd0, cycle}, 8'd31);
        check("slot31_c31", {7'd0, cycle_31}, 8'd1);
        period();
        check("wrap0", {3'd0, cycle}, 8'd0);
        check("wrap0_c31", {7'd0, cycle_31}, 8'd0);

        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (!pcen_n || !ncen_n) seq_err++;
        end
        check("freeze_cycle", {3'd0, cycle}, 8'd0);
        check("freeze_ic", {7'd0, ic_out_n}, 8'd1);
        phim(p, n);
        check("resume_pcen", {7'd0, p}, 8'd0);
        check("resume_cycle", {3'd0, cycle}, 8'd1);
        phim(p, n);
        check("resume_ncen", {7'd0, n}, 8'd0);

        for (int k = 0; k < 16; k++) period();
        check("slot17", {3'd0, cycle}, 8'd17);
        ic_n = 1'b0;
        period();
        check("icp1_ic", {7'd0, ic_out_n}, 8'd1);
        check("icp1_cycle", {3'd0, cycle}, 8'd18);
        period();
        check("icp2_ic", {7'd0, ic_out_n}, 8'd1);
        period();
        check("icp3_ic", {7'd0, ic_out_n}, 8'd0);
        check("icp3_cycle", {3'd0, cycle}, 8'd0);

        ic_n = 1'b1;
        period();
        period();
        for (int k = 0; k < MID_N; k++) period();
        ic_n = 1'b0;
        period();
        period();
        ic_n = 1'b1;
        period();
        period();
        check("rerel_ic_low", {7'd0, ic_out_n}, 8'd0);
        for (int k = 1; k < REL_N; k++) period();
        check("rerel_before", {7'd0, ic_out_n}, 8'd0);
        period();
        check("rerel_release", {7'd0, ic_out_n}, 8'd1);
        period();
        phim(p, n);
        check("pre_rst_cycle", {3'd0, cycle}, 8'd2);

        @(negedge clk);
        rst_n     = 1'b0;
        phimcen_n = 1'b0;
        #1;
        check("mid_rst_pcen", {7'd0, pcen_n}, 8'd1);
        check("mid_rst_ncen", {7'd0, ncen_n}, 8'd1);
        check("mid_rst_cycle", {3'd0, cycle}, 8'd0);
        check("mid_rst_ic", {7'd0, ic_out_n}, 8'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        phimcen_n = 1'b1;
        phim(p, n);
        check("post_rst_pcen", {7'd0, p}, 8'd0);
        check("post_rst_ncen", {7'd0, n}, 8'd1);

        check("enable_sequence_errors", 8'(seq_err), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
